pacman_clk_enable: RTL and testbench

- Consumes the 21.6 MHz divided output of the 27 MHz -> 64.8 MHz system PLL.
- Generates single-cycle clock enables for the Pac-Man core: 6.144 MHz pixel enable, 3.072 MHz CPU enable and 96 kHz sound enable. The pixel enable is derived with a fractional phase accumulator.
- Also sequences the core reset: after the board reset releases, core reset is held for a fixed number of pixel enables.
- All core logic runs on this single clock, qualified by these enables.

---
 rtl/pacman_clk_enable.sv | 129 ++++++++++++
 tb/tb_pacman_clk_enable.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pacman_clk_enable.sv
// Pac-Man clock enables (pixel via fractional accumulator, CPU and sound by division) plus core reset sequencing.
// Every output comes straight from a flop, one clk after the edge that decides it; pause freezes all state and zeroes the enables.
module pacman_clk_enable #(
  parameter int INC        = 64,
  parameter int MOD        = 225,
  parameter int ACC_W      = 8,
  parameter int CPU_DIV    = 2,
  parameter int SND_DIV    = 64,
  parameter int RST_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pause,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_snd,
  output logic rst_core,
  output logic running
);

  localparam int CPU_W  = $clog2(CPU_DIV);
  localparam int SND_W  = $clog2(SND_DIV);
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [ACC_W:0]    INC_X     = (ACC_W+1)'(INC);
  localparam logic [ACC_W:0]    MOD_X     = (ACC_W+1)'(MOD);
  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);
  localparam logic [SND_W-1:0]  SND_LAST  = SND_W'(SND_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CPU_W-1:0]  cpu_cnt_q, cpu_cnt_d;
  logic [SND_W-1:0]  snd_cnt_q, snd_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              ce_pix_q, ce_pix_d;
  logic              ce_cpu_q, ce_cpu_d;
  logic              ce_snd_q, ce_snd_d;

  logic [ACC_W:0]    sum;
  logic              pix_evt;

  // One extra bit on the sum so the wrap test never overflows.
  assign sum     = {1'b0, acc_q} + INC_X;
  assign pix_evt = !pause && (sum >= MOD_X);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cpu_cnt_d  = cpu_cnt_q;
    snd_cnt_d  = snd_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ce_pix_d   = 1'b0;
    ce_cpu_d   = 1'b0;
    ce_snd_d   = 1'b0;

    if (!pause) begin
      acc_d    = pix_evt ? ACC_W'(sum - MOD_X) : sum[ACC_W-1:0];
      ce_pix_d = pix_evt;
    end

    case (state_q)
      HOLD: begin
        // The releasing event leaves the dividers at zero, so the first
        // CPU enable lands on the second pixel event the core sees.
        if (pix_evt) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      RUN: begin
        if (pix_evt) begin
          if (cpu_cnt_q == CPU_LAST) begin
            cpu_cnt_d = '0;
            ce_cpu_d  = 1'b1;
          end else begin
            cpu_cnt_d = cpu_cnt_q + CPU_W'(1);
          end
          if (snd_cnt_q == SND_LAST) begin
            snd_cnt_d = '0;
            ce_snd_d  = 1'b1;
          end else begin
            snd_cnt_d = snd_cnt_q + SND_W'(1);
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      acc_q      <= '0;
      cpu_cnt_q  <= '0;
      snd_cnt_q  <= '0;
      hold_cnt_q <= '0;
      ce_pix_q   <= 1'b0;
      ce_cpu_q   <= 1'b0;
      ce_snd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cpu_cnt_q  <= cpu_cnt_d;
      snd_cnt_q  <= snd_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ce_pix_q   <= ce_pix_d;
      ce_cpu_q   <= ce_cpu_d;
      ce_snd_q   <= ce_snd_d;
    end
  end

  // Reset and run flags decode the state flop directly, so they change
  // on the same edge as the releasing pixel enable.
  assign ce_pix   = ce_pix_q;
  assign ce_cpu   = ce_cpu_q;
  assign ce_snd   = ce_snd_q;
  assign rst_core = (state_q == HOLD);
  assign running  = (state_q == RUN);

endmodule

// File: tb/tb_pacman_clk_enable.sv
// Bench for pacman_clk_enable: fixed release vectors, hand-built corner sequences and random pause against a counting model.
module tb_pacman_clk_enable;

  localparam int INC     = 64;
  localparam int MOD     = 225;
  localparam int CPU_DIV = 2;
  localparam int SND_DIV = 64;
  localparam int RST     = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic pause;
  logic ce_pix, ce_cpu, ce_snd, rst_core, running;
  logic [4:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: n_act unpaused edges since release, k_ev pixel events so far.
  int n_act = 0;
  int k_ev  = 0;

  always #5 clk = ~clk;

  pacman_clk_enable #(
    .INC(INC), .MOD(MOD), .ACC_W(8),
    .CPU_DIV(CPU_DIV), .SND_DIV(SND_DIV), .RST_CYCLES(RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pause(pause),
    .ce_pix(ce_pix), .ce_cpu(ce_cpu), .ce_snd(ce_snd),
    .rst_core(rst_core), .running(running)
  );

  assign outs = {ce_pix, ce_cpu, ce_snd, rst_core, running};

  typedef struct {
    logic       pause;
    logic [4:0] exp;
  } vec_t;

  vec_t vec [22];

  task automatic check_vec(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pix/cpu/snd/rst/run=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel event count after n unpaused edges is floor(n*INC/MOD).
  task automatic step(input logic p);
    logic ev;
    logic [4:0] exp;
    int j;
    pause = p;
    @(posedge clk);
    #1;
    ev = 1'b0;
    if (!p) begin
      n_act++;
      ev = ((n_act * INC) / MOD) != (((n_act - 1) * INC) / MOD);
    end
    exp = '0;
    if (ev) begin
      k_ev++;
      exp[4] = 1'b1;
      if (k_ev > RST) begin
        j = k_ev - RST;
        exp[3] = (j % CPU_DIV) == 0;
        exp[2] = (j % SND_DIV) == 0;
      end
    end
    exp[1] = k_ev < RST;
    exp[0] = k_ev >= RST;
    check_vec("model", outs, exp);
  endtask

  // Called just after a posedge; asserts reset between edges, releases at the next negedge.
  task automatic do_reset();
    pause   = 1'b0;
    reset_n = 1'b0;
    #1;
    check_vec("reset_outputs", outs, 5'b00010);
    @(negedge clk);
    reset_n = 1'b1;
    n_act = 0;
    k_ev  = 0;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 22; i++) begin
      step(vec[i].pause);
      check_vec(name, outs, vec[i].exp);
    end
  endtask

  initial begin
    // Edges 1..22 after release: pixel events at 4, 8, 11, 15, 18, 22;
    // release on the 4th (edge 15); first CPU enable on post-release event 2.
    for (int i = 0; i < 22; i++) vec[i] = '{1'b0, 5'b00010};
    vec[3]  = '{1'b0, 5'b10010};
    vec[7]  = '{1'b0, 5'b10010};
    vec[10] = '{1'b0, 5'b10010};
    vec[14] = '{1'b0, 5'b10001};
    for (int i = 15; i < 22; i++) vec[i] = '{1'b0, 5'b00001};
    vec[17] = '{1'b0, 5'b10001};
    vec[21] = '{1'b0, 5'b11001};

    reset_n = 1'b0;
    pause   = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset_state", outs, 5'b00010);
    reset_n = 1'b1;
    run_table("release_vec");

    // Steady RUN: ten whole accumulator periods.
    begin
      int np, nc, ns, last, gap_bad, off_pix;
      np = 0; nc = 0; ns = 0; last = -1; gap_bad = 0; off_pix = 0;
      for (int c = 0; c < 2250; c++) begin
        step(1'b0);
        if (ce_pix) begin
          np++;
          if (last >= 0 && (c - last < 3 || c - last > 4)) gap_bad++;
          last = c;
        end
        if (ce_cpu) nc++;
        if (ce_snd) ns++;
        if ((ce_cpu || ce_snd) && !ce_pix) off_pix++;
      end
      check_int("steady_pix_count", np, 640);
      check_int("steady_cpu_count", nc, 320);
      check_int("steady_snd_count", ns, 10);
      check_int("steady_pix_gap", gap_bad, 0);
      check_int("steady_ce_off_pix", off_pix, 0);
    end

    // Pause 37 clks mid-RUN; the model resumes from the same phase.
    begin
      int leak;
      leak = 0;
      for (int c = 0; c < 37; c++) begin
        step(1'b1);
        if (ce_pix || ce_cpu || ce_snd) leak++;
      end
      check_int("pause_ce_leak", leak, 0);
      repeat (60) step(1'b0);
    end

    // Async reset between edges, then the release timing must repeat.
    @(posedge clk);
    #2;
    do_reset();
    check_vec("async_reset_hold", outs, 5'b00010);
    run_table("rerelease_vec");

    // First sound enable: post-release pixel event 64, with CPU enable.
    begin
      int found;
      found = 0;
      for (int c = 0; c < 1000 && found == 0; c++) begin
        step(1'b0);
        if (ce_snd) begin
          found = 1;
          check_int("first_snd_event", k_ev - RST, 64);
          check_int("first_snd_with_cpu", int'(ce_cpu), 1);
        end
      end
      check_int("first_snd_seen", found, 1);
    end

    // Pause 10 clks in HOLD after the 2nd pixel enable: release moves from edge 15 to 25.
    do_reset();
    begin
      int cyc, npix, rel;
      cyc = 0; npix = 0; rel = -1;
      while (npix < 2 && cyc < 100) begin
        step(1'b0);
        cyc++;
        if (ce_pix) npix++;
      end
      check_int("hold_second_pix_edge", cyc, 8);
      repeat (10) begin
        step(1'b1);
        cyc++;
      end
      while (rel < 0 && cyc < 100) begin
        step(1'b0);
        cyc++;
        if (!rst_core) rel = cyc;
      end
      check_int("hold_pause_release_edge", rel, 25);
    end

    // Random pause traffic against the model.
    for (int c = 0; c < 2000; c++) step($urandom_range(0, 9) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
